secventiator_urmarire: RTL and testbench

Line-follower motion controller. It samples the three IR line sensors and drives the left/right motor command bits. When the line is lost it runs a timed recovery sequence: hold last heading, then pivot search toward the last known side, then stop and flag "lost". It replaces ad-hoc delay logic with one clocked FSM plus an internal tick prescaler, and sits between the sensor inputs and the H-bridge drivers.

---
 rtl/secventiator_urmarire_if.sv | 21 ++
 rtl/secventiator_urmarire.sv | 189 ++++++++++++++++++
 tb/tb_secventiator_urmarire.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/secventiator_urmarire_if.sv
// Sensor/motor bundle for the line-follower controller.
// Master side (stimulus) drives enable and senzor and reads the motor commands, state and lost flag.
// Slave side is the controller, which registers every output and samples senzor through a synchronizer.
interface secventiator_urmarire_if;
  logic       enable;    // run switch, 0 forces IDLE
  logic [2:0] senzor;    // {left, center, right}, 1 = line seen
  logic [1:0] motor_st;  // left motor: 00 stop, 01 forward, 10 reverse
  logic [1:0] motor_dr;  // right motor, same encoding
  logic [2:0] stare;     // IDLE=0 FOLLOW=1 HOLD=2 SEARCH=3 LOST=4
  logic       pierdut;   // high only in LOST

  modport master (
    output enable, senzor,
    input  motor_st, motor_dr, stare, pierdut
  );

  modport slave (
    input  enable, senzor,
    output motor_st, motor_dr, stare, pierdut
  );
endinterface

// File: rtl/secventiator_urmarire.sv
// Line-follower motion controller: steers from 3 IR sensors and runs a timed hold/search/lost recovery when the line vanishes.
// Latency: senzor change reaches the motors on the 3rd rising edge (2 sync flops + registered outputs).
// Backpressure: none; the H-bridge outputs are level commands updated every cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport: enable, senzor in; motor_st, motor_dr, stare, pierdut out).
module secventiator_urmarire #(
  parameter int TICK_DIV     = 5_000_000,
  parameter int HOLD_TICKS   = 10,
  parameter int SEARCH_TICKS = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  secventiator_urmarire_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FOLLOW = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_SEARCH = 3'd3;
  localparam logic [2:0] S_LOST   = 3'd4;

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_REV  = 2'b10;

  localparam int PW   = $clog2(TICK_DIV);
  localparam int TMAX = (HOLD_TICKS > SEARCH_TICKS) ? HOLD_TICKS : SEARCH_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  // last_dir encoding: 0 = line was last seen on the left, 1 = on the right
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [2:0]    r_sync1, r_sync2;
  logic [2:0]    r_stare;
  logic [1:0]    r_motor_st, r_motor_dr;
  logic          r_pierdut;
  logic          r_last_dir;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_ticks;

  logic [2:0]    w_stare;
  logic [1:0]    w_motor_st, w_motor_dr;
  logic          w_last_dir;
  logic          w_apply;
  logic [1:0]    w_steer_st, w_steer_dr;
  logic          w_steer_upd, w_steer_dir;
  logic          w_sens, w_tick, w_hold_done, w_search_done, w_run;
  logic [1:0]    w_pivot_st, w_pivot_dr;

  // Steering table from the synchronized sensors; only the side patterns update last_dir.
  always_comb begin
    w_steer_st  = M_STOP;
    w_steer_dr  = M_STOP;
    w_steer_upd = 1'b0;
    w_steer_dir = DIR_LEFT;
    case (r_sync2)
      3'b010, 3'b111, 3'b101: begin
        w_steer_st = M_FWD;
        w_steer_dr = M_FWD;
      end
      3'b100, 3'b110: begin
        w_steer_st  = M_STOP;
        w_steer_dr  = M_FWD;
        w_steer_upd = 1'b1;
        w_steer_dir = DIR_LEFT;
      end
      3'b001, 3'b011: begin
        w_steer_st  = M_FWD;
        w_steer_dr  = M_STOP;
        w_steer_upd = 1'b1;
        w_steer_dir = DIR_RIGHT;
      end
      default: ;
    endcase
  end

  assign w_sens        = |r_sync2;
  assign w_tick        = (r_presc == PW'(TICK_DIV - 1));
  assign w_hold_done   = w_tick && (r_ticks == TW'(HOLD_TICKS - 1));
  assign w_search_done = w_tick && (r_ticks == TW'(SEARCH_TICKS - 1));
  assign w_pivot_st    = (r_last_dir == DIR_LEFT) ? M_REV : M_FWD;
  assign w_pivot_dr    = (r_last_dir == DIR_LEFT) ? M_FWD : M_REV;

  // Priority: enable low, then sensor recovery, then timeout.
  always_comb begin
    w_stare    = r_stare;
    w_motor_st = r_motor_st;
    w_motor_dr = r_motor_dr;
    w_last_dir = r_last_dir;
    w_apply    = 1'b0;
    if (!bus.enable) begin
      w_stare    = S_IDLE;
      w_motor_st = M_STOP;
      w_motor_dr = M_STOP;
    end else begin
      case (r_stare)
        S_IDLE: begin
          w_stare    = S_FOLLOW;
          w_motor_st = M_STOP;
          w_motor_dr = M_STOP;
        end
        S_FOLLOW: begin
          if (w_sens) w_apply = 1'b1;
          else        w_stare = S_HOLD;   // motors keep the last heading
        end
        S_HOLD: begin
          if (w_sens) begin
            w_stare = S_FOLLOW;
            w_apply = 1'b1;
          end else if (w_hold_done) begin
            w_stare    = S_SEARCH;
            w_motor_st = w_pivot_st;
            w_motor_dr = w_pivot_dr;
          end
        end
        S_SEARCH: begin
          if (w_sens) begin
            w_stare = S_FOLLOW;
            w_apply = 1'b1;
          end else if (w_search_done) begin
            w_stare    = S_LOST;
            w_motor_st = M_STOP;
            w_motor_dr = M_STOP;
          end else begin
            w_motor_st = w_pivot_st;
            w_motor_dr = w_pivot_dr;
          end
        end
        S_LOST: begin
          w_motor_st = M_STOP;
          w_motor_dr = M_STOP;
        end
        default: begin
          w_stare    = S_IDLE;
          w_motor_st = M_STOP;
          w_motor_dr = M_STOP;
        end
      endcase
      if (w_apply) begin
        w_motor_st = w_steer_st;
        w_motor_dr = w_steer_dr;
        if (w_steer_upd) w_last_dir = w_steer_dir;
      end
    end
  end

  // Timers run only while staying in HOLD/SEARCH; any state change clears them,
  // so each recovery phase starts counting from zero.
  assign w_run = ((r_stare == S_HOLD) || (r_stare == S_SEARCH)) && (w_stare == r_stare);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stare    <= S_IDLE;
      r_motor_st <= M_STOP;
      r_motor_dr <= M_STOP;
      r_pierdut  <= 1'b0;
      r_last_dir <= DIR_LEFT;
      r_presc    <= '0;
      r_ticks    <= '0;
    end else begin
      r_sync1    <= bus.senzor;
      r_sync2    <= r_sync1;
      r_stare    <= w_stare;
      r_motor_st <= w_motor_st;
      r_motor_dr <= w_motor_dr;
      r_pierdut  <= (w_stare == S_LOST);
      r_last_dir <= w_last_dir;
      if (w_run) begin
        if (w_tick) begin
          r_presc <= '0;
          if (r_ticks != TW'(TMAX)) r_ticks <= r_ticks + TW'(1);
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end else begin
        r_presc <= '0;
        r_ticks <= '0;
      end
    end
  end

  assign bus.stare    = r_stare;
  assign bus.motor_st = r_motor_st;
  assign bus.motor_dr = r_motor_dr;
  assign bus.pierdut  = r_pierdut;

endmodule

// File: tb/tb_secventiator_urmarire.sv
// Directed bench for the line-follower controller with TICK_DIV=4, HOLD_TICKS=2, SEARCH_TICKS=3
// (HOLD lasts 8 cycles, SEARCH 12). Observed vector is {stare, motor_st, motor_dr, pierdut}.
module tb_secventiator_urmarire;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  secventiator_urmarire_if bus_if ();

  secventiator_urmarire #(
    .TICK_DIV    (4),
    .HOLD_TICKS  (2),
    .SEARCH_TICKS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [7:0] obs();
    return {bus_if.stare, bus_if.motor_st, bus_if.motor_dr, bus_if.pierdut};
  endfunction

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.enable = 1'b0;
    bus_if.senzor = 3'b000;
    step(2);
    checks++;
    if (obs() !== 8'b000_00_00_0) begin
      errors++; $display("FAIL reset_state: got %b want %b", obs(), 8'b000_00_00_0);
    end
    bus_if.enable = 1'b1;
    bus_if.senzor = 3'b010;
    step(1);
    checks++;
    if (obs() !== 8'b000_00_00_0) begin
      errors++; $display("FAIL reset_held: got %b want %b", obs(), 8'b000_00_00_0);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (obs() !== 8'b001_00_00_0) begin
      errors++; $display("FAIL idle_to_follow: got %b want %b", obs(), 8'b001_00_00_0);
    end
    step(2);
    checks++;
    if (obs() !== 8'b001_01_01_0) begin
      errors++; $display("FAIL first_forward: got %b want %b", obs(), 8'b001_01_01_0);
    end
  endtask

  task automatic test_loss_left();
    bus_if.senzor = 3'b110;
    step(3);
    checks++;
    if (obs() !== 8'b001_00_01_0) begin
      errors++; $display("FAIL steer_left: got %b want %b", obs(), 8'b001_00_01_0);
    end
    bus_if.senzor = 3'b000;
    step(3);
    checks++;
    if (obs() !== 8'b010_00_01_0) begin
      errors++; $display("FAIL hold_entry: got %b want %b", obs(), 8'b010_00_01_0);
    end
    for (int i = 1; i <= 7; i++) begin
      step(1);
      checks++;
      if (obs() !== 8'b010_00_01_0) begin
        errors++; $display("FAIL hold_cycle %0d: got %b want %b", i, obs(), 8'b010_00_01_0);
      end
    end
    step(1);
    checks++;
    if (obs() !== 8'b011_10_01_0) begin
      errors++; $display("FAIL search_entry_left: got %b want %b", obs(), 8'b011_10_01_0);
    end
    for (int i = 1; i <= 11; i++) begin
      step(1);
      checks++;
      if (obs() !== 8'b011_10_01_0) begin
        errors++; $display("FAIL search_cycle %0d: got %b want %b", i, obs(), 8'b011_10_01_0);
      end
    end
    step(1);
    checks++;
    if (obs() !== 8'b100_00_00_1) begin
      errors++; $display("FAIL lost_entry: got %b want %b", obs(), 8'b100_00_00_1);
    end
    step(10);
    checks++;
    if (obs() !== 8'b100_00_00_1) begin
      errors++; $display("FAIL lost_held: got %b want %b", obs(), 8'b100_00_00_1);
    end
  endtask

  task automatic test_lost_exit();
    bus_if.senzor = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      checks++;
      if (obs() !== 8'b100_00_00_1) begin
        errors++; $display("FAIL lost_ignores_sensor %0d: got %b want %b", i, obs(), 8'b100_00_00_1);
      end
    end
    bus_if.enable = 1'b0;
    step(1);
    checks++;
    if (obs() !== 8'b000_00_00_0) begin
      errors++; $display("FAIL lost_to_idle: got %b want %b", obs(), 8'b000_00_00_0);
    end
    step(2);
    bus_if.enable = 1'b1;
    step(1);
    checks++;
    if (obs() !== 8'b001_00_00_0) begin
      errors++; $display("FAIL rearm_follow: got %b want %b", obs(), 8'b001_00_00_0);
    end
    step(1);
    checks++;
    if (obs() !== 8'b001_01_01_0) begin
      errors++; $display("FAIL rearm_forward: got %b want %b", obs(), 8'b001_01_01_0);
    end
  endtask

  task automatic test_loss_right();
    bus_if.senzor = 3'b011;
    step(3);
    checks++;
    if (obs() !== 8'b001_01_00_0) begin
      errors++; $display("FAIL steer_right: got %b want %b", obs(), 8'b001_01_00_0);
    end
    bus_if.senzor = 3'b000;
    step(3);
    checks++;
    if (obs() !== 8'b010_01_00_0) begin
      errors++; $display("FAIL hold_right: got %b want %b", obs(), 8'b010_01_00_0);
    end
    step(8);
    checks++;
    if (obs() !== 8'b011_01_10_0) begin
      errors++; $display("FAIL search_entry_right: got %b want %b", obs(), 8'b011_01_10_0);
    end
    step(4);
    bus_if.senzor = 3'b001;
    step(2);
    checks++;
    if (obs() !== 8'b011_01_10_0) begin
      errors++; $display("FAIL search_before_recover: got %b want %b", obs(), 8'b011_01_10_0);
    end
    step(1);
    checks++;
    if (obs() !== 8'b001_01_00_0) begin
      errors++; $display("FAIL search_recover: got %b want %b", obs(), 8'b001_01_00_0);
    end
  endtask

  task automatic test_reset_mid_hold();
    bus_if.senzor = 3'b000;
    step(3);
    checks++;
    if (obs() !== 8'b010_01_00_0) begin
      errors++; $display("FAIL hold_before_reset: got %b want %b", obs(), 8'b010_01_00_0);
    end
    step(3);
    #2;
    rst_n = 1'b0;
    bus_if.senzor = 3'b010;
    #1;
    checks++;
    if (obs() !== 8'b000_00_00_0) begin
      errors++; $display("FAIL async_reset: got %b want %b", obs(), 8'b000_00_00_0);
    end
    step(2);
    rst_n = 1'b1;
    step(3);
    checks++;
    if (obs() !== 8'b001_01_01_0) begin
      errors++; $display("FAIL post_reset_forward: got %b want %b", obs(), 8'b001_01_01_0);
    end
    bus_if.senzor = 3'b000;
    step(11);
    checks++;
    if (obs() !== 8'b011_10_01_0) begin
      errors++; $display("FAIL post_reset_pivot_left: got %b want %b", obs(), 8'b011_10_01_0);
    end
  endtask

  task automatic test_collisions();
    bus_if.senzor = 3'b010;
    step(3);
    checks++;
    if (obs() !== 8'b001_01_01_0) begin
      errors++; $display("FAIL collide_setup: got %b want %b", obs(), 8'b001_01_01_0);
    end
    bus_if.senzor = 3'b000;
    step(3);
    step(5);
    bus_if.senzor = 3'b100;
    step(2);
    checks++;
    if (obs() !== 8'b010_01_01_0) begin
      errors++; $display("FAIL collide_hold_last: got %b want %b", obs(), 8'b010_01_01_0);
    end
    step(1);
    checks++;
    if (obs() !== 8'b001_00_01_0) begin
      errors++; $display("FAIL recovery_beats_timeout: got %b want %b", obs(), 8'b001_00_01_0);
    end
    bus_if.senzor = 3'b000;
    step(3);
    step(5);
    bus_if.senzor = 3'b010;
    step(2);
    checks++;
    if (obs() !== 8'b010_00_01_0) begin
      errors++; $display("FAIL collide2_hold_last: got %b want %b", obs(), 8'b010_00_01_0);
    end
    bus_if.enable = 1'b0;
    step(1);
    checks++;
    if (obs() !== 8'b000_00_00_0) begin
      errors++; $display("FAIL enable_beats_all: got %b want %b", obs(), 8'b000_00_00_0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.enable = 1'b0;
    bus_if.senzor = 3'b000;
    test_reset();
    test_loss_left();
    test_lost_exit();
    test_loss_right();
    test_reset_mid_hold();
    test_collisions();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
